triangle_raster_scan: RTL and testbench
=======================================

// Module: triangle_raster_scan
// PURPOSE
//   Drives the point-in-triangle tester (triangulo) across the bounding box of triangle A,B,C, collects its
//   inside flag, and emits the covered pixels as a valid/ready stream plus a final covered-pixel count.
//   Replaces the hand-written px/py sweep: it is the scan-and-collect end of the tester's point interface.
// PARAMETERS
//   CW       9   coordinate width (px, py, vertices)
//   TEST_LAT 1   cycles from px/py/pt_valid driven to in_s valid (tester latency, >=0)
//   CNT_W    19  inside_count width (holds 512*512)
//   FDEPTH   4   output FIFO depth, must be >= TEST_LAT+1
// PORTS
//   clk          in   1      clock, all logic on posedge
//   rst_n        in   1      synchronous reset, active low
//   start        in   1      begin a scan; sampled only in IDLE
//   ax,ay,bx,by,cx,cy in CW  triangle vertices, latched on accepted start
//   px, py       out  CW     point presented to the tester
//   pt_valid     out  1      px/py hold a real point this cycle
//   in_s         in   1      tester result for the point issued TEST_LAT cycles earlier
//   pix_valid    out  1      output pixel available
//   pix_ready    in   1      consumer accepts pixel
//   pix_x, pix_y out  CW     covered pixel coordinates
//   busy         out  1      high from accepted start until done
//   done         out  1      one-cycle pulse at scan end
//   inside_count out  CNT_W  number of covered pixels of the last/current scan
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state IDLE; px,py,pt_valid,pix_valid,busy,done=0; inside_count=0; FIFO
//     emptied; in-flight pipe cleared. Reset mid-scan aborts immediately, no done pulse.
//   FSM: IDLE -start-> SETUP -> SCAN -last point issued-> DRAIN -pipe+FIFO empty-> DONE -> IDLE.
//   SETUP (1 cycle): xmin/xmax/ymin/ymax = unsigned min/max of latched vertices; inside_count cleared.
//   SCAN order: py inner, px outer: start (xmin,ymin); if py<ymax py++ else {py=ymin; px++}; last point is
//     (xmax,ymax). Degenerate box (all vertices equal) issues exactly one point.
//   Issue rule: point issued (pt_valid=1) in a cycle iff inflight + fifo_count < FDEPTH; else pt_valid=0 and
//     px/py hold. No point is ever dropped.
//   Return path: TEST_LAT-deep shift of {valid,px,py}; when returning valid and in_s=1, push {px,py} into
//     FIFO and inside_count++ (same cycle). in_s ignored when returning valid=0.
//   Output: pix_valid = FIFO non-empty; pop on pix_valid&&pix_ready; pix_x/pix_y stable while stalled.
//     Simultaneous push and pop on a full FIFO is legal (credit rule guarantees no overflow).
//   done asserted for exactly the cycle in DONE; busy=1 in SETUP..DRAIN, 0 in DONE/IDLE.
//   start while busy ignored; start in the DONE cycle ignored. inside_count holds until next SETUP.
//   Arithmetic unsigned, CW bits; px/py never wrap since bounds are vertex values.
// STRUCTURE
//   Package raster_pkg: CW default, state enum (IDLE,SETUP,SCAN,DRAIN,DONE) localparams, pixel struct width.
//   One sub-module: raster_pix_fifo (sync FIFO, FDEPTH x 2*CW, count output). Delay line and FSM inline.
// TESTING
//   Triangle (3,3),(6,12),(9,8), TEST_LAT=1, golden tester model, pix_ready=1 -> 70 points issued in py-inner
//     order from (3,3) to (9,12); pixel stream and inside_count match model; done pulses once.
//   All vertices (5,5) -> exactly one point (5,5); if model says inside, one pixel, inside_count=1.
//   pix_ready=0 for 40 cycles mid-scan -> pt_valid stalls once FIFO+inflight=FDEPTH; no pixel lost/duplicated.
//   TEST_LAT=3, random pix_ready 50% -> stream identical to TEST_LAT=1 run; inside_count equal.
//   rst_n low for 1 cycle during SCAN -> all outputs 0 next cycle, no done; new start rescans correctly.
//   start pulsed while busy and in DONE cycle -> ignored; vertices changed during scan have no effect.

Source files
------------

// File: rtl/triangle_raster_scan_pkg.sv
// Shared defaults, FSM state encoding and pixel word width for the triangle raster scanner.
package raster_pkg;

   localparam int CW_DEF       = 9;
   localparam int TEST_LAT_DEF = 1;
   localparam int CNT_W_DEF    = 19;
   localparam int FDEPTH_DEF   = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SCAN  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // A queued pixel is {x, y}.
   function automatic int pix_w(input int cw);
      return 2 * cw;
   endfunction

endpackage

// File: rtl/triangle_raster_scan_fifo.sv
// Small synchronous FIFO holding covered pixels until the consumer takes them.
module raster_pix_fifo #(
   parameter int W     = 18,
   parameter int DEPTH = 4,
   parameter int CNTW  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [W-1:0]    push_data,
   input  logic            pop,
   output logic [W-1:0]    rd_data,
   output logic            empty,
   output logic [CNTW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [W-1:0]    mem_q [DEPTH];
   logic            do_pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      if (push) begin
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      // Push and pop together on a full FIFO leave the count unchanged.
      case ({push, do_pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/triangle_raster_scan.sv
// Sweeps the bounding box of triangle A,B,C through an external point tester and
// streams back the covered pixels, with credit flow control so no result is lost.
module triangle_raster_scan
   import raster_pkg::*;
#(
   parameter int CW       = CW_DEF,
   parameter int TEST_LAT = TEST_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int FDEPTH   = FDEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CW-1:0]    ax,
   input  logic [CW-1:0]    ay,
   input  logic [CW-1:0]    bx,
   input  logic [CW-1:0]    by,
   input  logic [CW-1:0]    cx,
   input  logic [CW-1:0]    cy,
   output logic [CW-1:0]    px,
   output logic [CW-1:0]    py,
   output logic             pt_valid,
   input  logic             in_s,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [CW-1:0]    pix_x,
   output logic [CW-1:0]    pix_y,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] inside_count,
   output logic [2:0]       dbg_state
);

   localparam int PW  = pix_w(CW);
   localparam int FCW = $clog2(FDEPTH + 1);
   localparam int PL  = (TEST_LAT == 0) ? 1 : TEST_LAT;

   state_t           state_q, state_d;
   logic [CW-1:0]    ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
   logic [CW-1:0]    ax_d, ay_d, bx_d, by_d, cx_d, cy_d;
   logic [CW-1:0]    xmax_q, ymin_q, ymax_q, xmax_d, ymin_d, ymax_d;
   logic [CW-1:0]    px_q, py_q, px_d, py_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CW-1:0]    xlo, xhi, ylo, yhi;

   logic [PL-1:0]    pipe_v_q, pipe_v_d;
   logic [CW-1:0]    pipe_x_q [PL];
   logic [CW-1:0]    pipe_y_q [PL];
   logic [CW-1:0]    pipe_x_d [PL];
   logic [CW-1:0]    pipe_y_d [PL];
   logic [7:0]       inflight;
   logic             ret_v;
   logic [CW-1:0]    ret_x, ret_y;

   logic             push, pop, fifo_empty, last_pt;
   logic [PW-1:0]    fifo_rd;
   logic [FCW-1:0]   fifo_count;

   always_comb begin
      xlo = (ax_q < bx_q) ? ax_q : bx_q;
      xlo = (cx_q < xlo)  ? cx_q : xlo;
      xhi = (ax_q > bx_q) ? ax_q : bx_q;
      xhi = (cx_q > xhi)  ? cx_q : xhi;
      ylo = (ay_q < by_q) ? ay_q : by_q;
      ylo = (cy_q < ylo)  ? cy_q : ylo;
      yhi = (ay_q > by_q) ? ay_q : by_q;
      yhi = (cy_q > yhi)  ? cy_q : yhi;
   end

   // Issue credit: every point in the pipe or result in the FIFO holds one FIFO slot,
   // so a result returning from the tester always finds room.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < PL; i++) begin
         if (pipe_v_q[i]) inflight = inflight + 8'd1;
      end
      if (TEST_LAT == 0) inflight = '0;
   end

   assign pt_valid = (state_q == ST_SCAN) && ((inflight + 8'(fifo_count)) < 8'(FDEPTH));
   assign last_pt  = (px_q == xmax_q) && (py_q == ymax_q);

   always_comb begin
      pipe_v_d    = pipe_v_q;
      pipe_x_d    = pipe_x_q;
      pipe_y_d    = pipe_y_q;
      for (int i = PL - 1; i > 0; i--) begin
         pipe_v_d[i] = pipe_v_q[i-1];
         pipe_x_d[i] = pipe_x_q[i-1];
         pipe_y_d[i] = pipe_y_q[i-1];
      end
      pipe_v_d[0] = pt_valid;
      pipe_x_d[0] = px_q;
      pipe_y_d[0] = py_q;
   end

   assign ret_v = (TEST_LAT == 0) ? pt_valid : pipe_v_q[PL-1];
   assign ret_x = (TEST_LAT == 0) ? px_q     : pipe_x_q[PL-1];
   assign ret_y = (TEST_LAT == 0) ? py_q     : pipe_y_q[PL-1];
   assign push  = ret_v && in_s;

   // Output stream: a pixel transfers on a cycle with pix_valid && pix_ready; while
   // pix_valid is high and pix_ready low, pix_x/pix_y stay unchanged.
   assign pop = pix_valid && pix_ready;

   always_comb begin
      state_d = state_q;
      ax_d = ax_q; ay_d = ay_q; bx_d = bx_q; by_d = by_q; cx_d = cx_q; cy_d = cy_q;
      xmax_d = xmax_q; ymin_d = ymin_q; ymax_d = ymax_q;
      px_d = px_q; py_d = py_q;
      cnt_d = cnt_q;
      if (push) cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ax_d = ax; ay_d = ay; bx_d = bx; by_d = by; cx_d = cx; cy_d = cy;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            xmax_d  = xhi;
            ymin_d  = ylo;
            ymax_d  = yhi;
            px_d    = xlo;
            py_d    = ylo;
            cnt_d   = '0;
            state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (pt_valid) begin
               if (last_pt) begin
                  state_d = ST_DRAIN;
               end else if (py_q < ymax_q) begin
                  py_d = py_q + CW'(1);
               end else begin
                  py_d = ymin_q;
                  px_d = px_q + CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if ((inflight == '0) && fifo_empty) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; cx_q <= '0; cy_q <= '0;
         xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
         px_q <= '0; py_q <= '0;
         cnt_q <= '0;
         pipe_v_q <= '0;
         for (int i = 0; i < PL; i++) begin
            pipe_x_q[i] <= '0;
            pipe_y_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ax_q <= ax_d; ay_q <= ay_d; bx_q <= bx_d; by_q <= by_d; cx_q <= cx_d; cy_q <= cy_d;
         xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
         px_q <= px_d; py_q <= py_d;
         cnt_q <= cnt_d;
         pipe_v_q <= pipe_v_d;
         pipe_x_q <= pipe_x_d;
         pipe_y_q <= pipe_y_d;
      end
   end

   raster_pix_fifo #(
      .W    (PW),
      .DEPTH(FDEPTH),
      .CNTW (FCW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_data({ret_x, ret_y}),
      .pop      (pop),
      .rd_data  (fifo_rd),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign px           = px_q;
   assign py           = py_q;
   assign pix_valid    = !fifo_empty;
   assign pix_x        = fifo_rd[PW-1:CW];
   assign pix_y        = fifo_rd[CW-1:0];
   assign busy         = (state_q == ST_SETUP) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
   assign done         = (state_q == ST_DONE);
   assign inside_count = cnt_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_triangle_raster_scan.sv
// Directed bench: two scanners (tester latency 1 and 3) driven by a golden point-in-triangle model.
module tb_triangle_raster_scan;

   localparam int CW = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start1, start3, rdy1, rdy3, rand3;
   logic [CW-1:0] ax, ay, bx, by, cx, cy;

   logic [CW-1:0] px1, py1, pxo1, pyo1, px3, py3, pxo3, pyo3;
   logic          ptv1, pv1, busy1, done1, ptv3, pv3, busy3, done3;
   logic          in1, in3, s3a, s3b;
   logic [18:0]   cnt1, cnt3;
   logic [2:0]    st1, st3;

   triangle_raster_scan #(.CW(CW), .TEST_LAT(1), .CNT_W(19), .FDEPTH(4)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
      .px(px1), .py(py1), .pt_valid(ptv1), .in_s(in1),
      .pix_valid(pv1), .pix_ready(rdy1), .pix_x(pxo1), .pix_y(pyo1),
      .busy(busy1), .done(done1), .inside_count(cnt1), .dbg_state(st1)
   );

   triangle_raster_scan #(.CW(CW), .TEST_LAT(3), .CNT_W(19), .FDEPTH(4)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
      .px(px3), .py(py3), .pt_valid(ptv3), .in_s(in3),
      .pix_valid(pv3), .pix_ready(rdy3), .pix_x(pxo3), .pix_y(pyo3),
      .busy(busy3), .done(done3), .inside_count(cnt3), .dbg_state(st3)
   );

   // Golden tester triangle, kept apart from the DUT vertex inputs.
   int tax, tay, tbx, tby, tcx, tcy;

   function automatic bit inside_tri(input int x, input int y);
      int e0, e1, e2;
      e0 = (tbx - tax) * (y - tay) - (tby - tay) * (x - tax);
      e1 = (tcx - tbx) * (y - tby) - (tcy - tby) * (x - tbx);
      e2 = (tax - tcx) * (y - tcy) - (tay - tcy) * (x - tcx);
      return ((e0 >= 0) && (e1 >= 0) && (e2 >= 0)) || ((e0 <= 0) && (e1 <= 0) && (e2 <= 0));
   endfunction

   always @(posedge clk) begin
      in1 <= inside_tri(int'(px1), int'(py1));
      s3a <= inside_tri(int'(px3), int'(py3));
      s3b <= s3a;
      in3 <= s3b;
   end

   logic [2*CW-1:0] iss1_q[$], pix1_q[$], iss3_q[$], pix3_q[$];
   logic [2*CW-1:0] exp_pts_q[$], exp_pix_q[$];
   int done_cnt1 = 0, done_cnt3 = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ptv1) iss1_q.push_back({px1, py1});
         if (pv1 && rdy1) pix1_q.push_back({pxo1, pyo1});
         if (done1) done_cnt1++;
         if (ptv3) iss3_q.push_back({px3, py3});
         if (pv3 && rdy3) pix3_q.push_back({pxo3, pyo3});
         if (done3) done_cnt3++;
      end
   end

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_q(input string tag, input logic [2*CW-1:0] obs[$], input logic [2*CW-1:0] exp[$]);
      chk({tag, "_len"}, obs.size(), exp.size());
      for (int i = 0; i < obs.size() && i < exp.size(); i++) chk(tag, obs[i], exp[i]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand3) rdy3 = 1'($urandom_range(0, 1));
   endtask

   task automatic set_tri(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
      int xmin, xmax, ymin, ymax;
      logic [2*CW-1:0] p;
      tax = x0; tay = y0; tbx = x1; tby = y1; tcx = x2; tcy = y2;
      ax = CW'(x0); ay = CW'(y0); bx = CW'(x1); by = CW'(y1); cx = CW'(x2); cy = CW'(y2);
      xmin = x0; if (x1 < xmin) xmin = x1; if (x2 < xmin) xmin = x2;
      xmax = x0; if (x1 > xmax) xmax = x1; if (x2 > xmax) xmax = x2;
      ymin = y0; if (y1 < ymin) ymin = y1; if (y2 < ymin) ymin = y2;
      ymax = y0; if (y1 > ymax) ymax = y1; if (y2 > ymax) ymax = y2;
      exp_pts_q.delete(); exp_pix_q.delete();
      iss1_q.delete(); pix1_q.delete(); iss3_q.delete(); pix3_q.delete();
      for (int x = xmin; x <= xmax; x++) begin
         for (int y = ymin; y <= ymax; y++) begin
            p = {CW'(x), CW'(y)};
            exp_pts_q.push_back(p);
            if (inside_tri(x, y)) exp_pix_q.push_back(p);
         end
      end
   endtask

   task automatic pulse_start();
      tick();
      start1 = 1'b1; start3 = 1'b1;
      tick();
      start1 = 1'b0; start3 = 1'b0;
   endtask

   // Waits for both scanners to finish; a start is held through each DONE cycle.
   task automatic run_until_done(input int budget);
      int c1, c3, n;
      c1 = done_cnt1; c3 = done_cnt3; n = 0;
      while (((done_cnt1 == c1) || (done_cnt3 == c3)) && (n < budget)) begin
         tick();
         n++;
         start1 = done1;
         start3 = done3;
      end
      start1 = 1'b0; start3 = 1'b0;
      chk("scan_timeout", 32'(n < budget), 1);
      repeat (6) tick();
      chk("done_pulses1", done_cnt1 - c1, 1);
      chk("done_pulses3", done_cnt3 - c3, 1);
      chk("busy1_after", busy1, 0);
      chk("busy3_after", busy3, 0);
   endtask

   task automatic check_run(input int hand_pts, input int hand_cnt);
      chk("issued1_n", iss1_q.size(), hand_pts);
      chk("issued3_n", iss3_q.size(), hand_pts);
      cmp_q("issued1", iss1_q, exp_pts_q);
      cmp_q("issued3", iss3_q, exp_pts_q);
      cmp_q("pix1", pix1_q, exp_pix_q);
      cmp_q("pix3", pix3_q, exp_pix_q);
      cmp_q("pix3_vs_pix1", pix3_q, pix1_q);
      chk("count1", cnt1, hand_cnt);
      chk("count3", cnt3, hand_cnt);
   endtask

   initial begin
      int c1, c3;
      rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
      rdy1 = 1'b1; rdy3 = 1'b1; rand3 = 1'b0;
      set_tri(0, 0, 0, 0, 0, 0);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pt_valid", ptv1, 0);
      chk("rst_px", px1, 0);
      chk("rst_py", py1, 0);
      chk("rst_pix_valid", pv1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_count", cnt1, 0);
      chk("rst_state", st1, 0);
      chk("rst_busy3", busy3, 0);
      rst_n = 1'b1;
      rand3 = 1'b1;
      tick();

      // Main triangle; vertices changed and start pulsed while busy.
      set_tri(3, 3, 6, 12, 9, 8);
      pulse_start();
      chk("busy1_setup", busy1, 1);
      repeat (5) tick();
      ax = 9'd0; ay = 9'd0; bx = 9'd1; by = 9'd1; cx = 9'd2; cy = 9'd2;
      start1 = 1'b1; start3 = 1'b1;
      tick();
      start1 = 1'b0; start3 = 1'b0;
      run_until_done(3000);
      check_run(70, 23);

      // Degenerate box: one point.
      set_tri(5, 5, 5, 5, 5, 5);
      pulse_start();
      run_until_done(200);
      check_run(1, 1);
      chk("degen_pix", pix1_q.size() > 0 ? pix1_q[0] : 18'h3ffff, {9'd5, 9'd5});

      // Consumer stall mid-scan on a dense triangle.
      set_tri(0, 0, 20, 0, 0, 20);
      pulse_start();
      repeat (20) tick();
      rdy1 = 1'b0;
      repeat (40) tick();
      chk("stall_pt_valid", ptv1, 0);
      chk("stall_pix_valid", pv1, 1);
      chk("stall_busy", busy1, 1);
      rdy1 = 1'b1;
      run_until_done(6000);
      check_run(441, 231);

      // Reset during SCAN aborts without done.
      set_tri(3, 3, 6, 12, 9, 8);
      pulse_start();
      repeat (10) tick();
      chk("pre_rst_state", st1, 2);
      c1 = done_cnt1; c3 = done_cnt3;
      rst_n = 1'b0;
      tick();
      chk("abort_pt_valid", ptv1, 0);
      chk("abort_px", px1, 0);
      chk("abort_py", py1, 0);
      chk("abort_pix_valid", pv1, 0);
      chk("abort_busy", busy1, 0);
      chk("abort_done", done1, 0);
      chk("abort_count", cnt1, 0);
      chk("abort_pix_valid3", pv3, 0);
      chk("abort_busy3", busy3, 0);
      rst_n = 1'b1;
      repeat (8) tick();
      chk("abort_no_done1", done_cnt1 - c1, 0);
      chk("abort_no_done3", done_cnt3 - c3, 0);
      chk("abort_idle", st1, 0);

      set_tri(3, 3, 6, 12, 9, 8);
      pulse_start();
      run_until_done(3000);
      check_run(70, 23);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
